// File: rtl/seven_seg_pkg.sv
// Shared constants and the BCD/hex digit decode for the multiplexed seven-segment driver.
// Patterns are active-high, bit order gfedcba.
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b0000000;

  localparam logic [6:0] PAT_0 = 7'b0111111;
  localparam logic [6:0] PAT_1 = 7'b0000110;
  localparam logic [6:0] PAT_2 = 7'b1011011;
  localparam logic [6:0] PAT_3 = 7'b1001111;
  localparam logic [6:0] PAT_4 = 7'b1100110;
  localparam logic [6:0] PAT_5 = 7'b1101101;
  localparam logic [6:0] PAT_6 = 7'b1111101;
  localparam logic [6:0] PAT_7 = 7'b0000111;
  localparam logic [6:0] PAT_8 = 7'b1111111;
  localparam logic [6:0] PAT_9 = 7'b1101111;
  localparam logic [6:0] PAT_A = 7'b1110111;
  localparam logic [6:0] PAT_B = 7'b1111100;
  localparam logic [6:0] PAT_C = 7'b0111001;
  localparam logic [6:0] PAT_D = 7'b1011110;
  localparam logic [6:0] PAT_E = 7'b1111001;
  localparam logic [6:0] PAT_F = 7'b1110001;

  // Values 10..15 are blank unless hex decoding is enabled.
  function automatic logic [6:0] decode_digit(input logic [3:0] value, input logic hex_en);
    logic [6:0] pat;
    case (value)
      4'h0:    pat = PAT_0;
      4'h1:    pat = PAT_1;
      4'h2:    pat = PAT_2;
      4'h3:    pat = PAT_3;
      4'h4:    pat = PAT_4;
      4'h5:    pat = PAT_5;
      4'h6:    pat = PAT_6;
      4'h7:    pat = PAT_7;
      4'h8:    pat = PAT_8;
      4'h9:    pat = PAT_9;
      4'hA:    pat = hex_en ? PAT_A : SEG_OFF;
      4'hB:    pat = hex_en ? PAT_B : SEG_OFF;
      4'hC:    pat = hex_en ? PAT_C : SEG_OFF;
      4'hD:    pat = hex_en ? PAT_D : SEG_OFF;
      4'hE:    pat = hex_en ? PAT_E : SEG_OFF;
      default: pat = hex_en ? PAT_F : SEG_OFF;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational digit decoder: 4-bit value plus blank request to an active-high gfedcba pattern.
// Define SEVEN_SEG_HEX_DECODE_EN to show A..F for values 10..15; otherwise they are blank.
module seven_seg_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] value,
  input  logic       blank,
  output logic [6:0] pattern
);

`ifdef SEVEN_SEG_HEX_DECODE_EN
  localparam logic HEX_EN = 1'b1;
`else
  localparam logic HEX_EN = 1'b0;
`endif

  assign pattern = blank ? SEG_OFF : decode_digit(value, HEX_EN);

endmodule

// File: rtl/seven_seg_scan_n.sv
// N-digit multiplexed seven-segment scanner with double-buffered load, PWM brightness,
// dead time, leading-zero blanking and selectable pin polarity. All pin outputs are registered.
module seven_seg_scan_n
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV_WIDTH      = 16,
  parameter int BRIGHT_WIDTH   = 3,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [4*NUM_DIGITS-1:0]   bcd_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      load_valid,
  output logic                      load_ready,
  input  logic                      blank_lz,
  input  logic [BRIGHT_WIDTH-1:0]   brightness,
  output logic [6:0]                seg,
  output logic                      dp,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  localparam logic [6:0]            SEG_INV = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  DP_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic [NUM_DIGITS-1:0] AN_INV  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  // Scan timing
  logic [DIV_WIDTH-1:0] prescaler;
  logic [IDX_W-1:0]     idx;
  logic                 slot_end;
  logic                 frame_end;

  // Double buffer
  logic [4*NUM_DIGITS-1:0] pending_bcd;
  logic [NUM_DIGITS-1:0]   pending_dp;
  logic                    pending_full;
  logic [4*NUM_DIGITS-1:0] display_bcd;
  logic [NUM_DIGITS-1:0]   display_dp;

  // Pre-register digit path
  logic [3:0]              cur_value;
  logic                    cur_dp;
  logic                    cur_lz;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   an_sel;
  logic [BRIGHT_WIDTH-1:0] sub_phase;
  logic                    an_on;
  logic [6:0]              pattern;

  assign slot_end   = &prescaler;
  assign frame_end  = slot_end && (idx == LAST_IDX);
  assign load_ready = !pending_full;

  // NOTE: sequential state is assigned with non-blocking (<=) so every register samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescaler <= '0;
      idx       <= '0;
    end else begin
      prescaler <= prescaler + DIV_WIDTH'(1);
      if (slot_end) begin
        idx <= frame_end ? '0 : idx + IDX_W'(1);
      end
    end
  end

  // NOTE: the display and pending buffers are reset as well, because a defined blank/zero
  // display and an empty pending slot after reset are part of the visible behaviour.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending_bcd  <= '0;
      pending_dp   <= '0;
      pending_full <= 1'b0;
      display_bcd  <= '0;
      display_dp   <= '0;
    end else if (frame_end && pending_full) begin
      // Commit only at the frame boundary; load_ready is low here, so no transfer collides.
      display_bcd  <= pending_bcd;
      display_dp   <= pending_dp;
      pending_full <= 1'b0;
    end else if (load_valid && !pending_full) begin
      pending_bcd  <= bcd_in;
      pending_dp   <= dp_in;
      pending_full <= 1'b1;
    end
  end

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    logic higher_zero;
    cur_value   = 4'd0;
    cur_dp      = 1'b0;
    cur_lz      = 1'b0;
    an_sel      = '0;
    higher_zero = 1'b1;
    // Walk from the most significant digit down so higher_zero means "this and all above are 0".
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      higher_zero = higher_zero && (display_bcd[4*k +: 4] == 4'd0);
      if (idx == IDX_W'(k)) begin
        cur_value = display_bcd[4*k +: 4];
        cur_dp    = display_dp[k];
        cur_lz    = higher_zero;
        an_sel[k] = 1'b1;
      end
    end
  end

  assign cur_blank = blank_lz && (idx != '0) && cur_lz;
  assign sub_phase = prescaler[DIV_WIDTH-1 -: BRIGHT_WIDTH];
  assign an_on     = (prescaler != '0) && (sub_phase <= brightness);

  seven_seg_decoder u_decoder (
    .value   (cur_value),
    .blank   (cur_blank),
    .pattern (pattern)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg        <= SEG_OFF ^ SEG_INV;
      dp         <= DP_INV;
      an         <= AN_INV;
      frame_done <= 1'b0;
    end else begin
      seg        <= pattern ^ SEG_INV;
      dp         <= cur_dp ^ DP_INV;
      an         <= (an_on ? an_sel : '0) ^ AN_INV;
      frame_done <= frame_end;
    end
  end

endmodule
